// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM arbiter: response-source encoding,
// default bus widths and a counter-width helper.
package ram_arb_pkg;

    localparam int unsigned DefaultAddrW = 30;
    localparam int unsigned DefaultDataW = 32;

    typedef enum logic [1:0] {
        RespNone = 2'd0,
        RespIf   = 2'd1,
        RespD    = 2'd2
    } resp_src_e;

    // A limit of 0 still needs a 1-bit counter so the port widths stay legal.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ram_arb_starve_cnt.sv
// Counts consecutive cycles in which a pending fetch loses to the data port and
// raises force_if once the configured limit is reached.
module ram_arb_starve_cnt
    import ram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req_i,
    input  logic if_gnt_i,
    input  logic if_lost_i,
    output logic force_if_o
);

    localparam int unsigned CntW = cnt_width(STARVE_LIMIT);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!if_req_i || if_gnt_i) begin
            wait_cnt_d = '0;
        end else if (if_lost_i && (wait_cnt_q != Limit)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign force_if_o = (STARVE_LIMIT != 0) && (wait_cnt_q == Limit);

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a single-port synchronous-read RAM between fetch and data ports.
// Optional RAM_ARB_STATS_EN adds saturating grant/conflict counters.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DefaultAddrW,
    parameter int unsigned DATA_W       = DefaultDataW,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              ram_wren_o,
    output logic [ADDR_W-1:0] ram_address_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_q_i
`ifdef RAM_ARB_STATS_EN
    ,
    input  logic              stat_clr_i,
    output logic [31:0]       stat_if_grants_o,
    output logic [31:0]       stat_d_grants_o,
    output logic [31:0]       stat_conflicts_o
`endif
);

    logic              force_if;
    logic              arb_if_gnt, arb_d_gnt;
    logic [ADDR_W-1:0] arb_addr;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    resp_src_e         resp_src_q, resp_src_d;

    // Internal decisions are left ungated; flops are held in reset anyway and
    // only the externally visible outputs are forced quiet.
    always_comb begin
        arb_if_gnt = 1'b0;
        arb_d_gnt  = 1'b0;
        if (if_req_i && (!d_req_i || force_if)) begin
            arb_if_gnt = 1'b1;
        end else if (d_req_i) begin
            arb_d_gnt = 1'b1;
        end

        if (arb_if_gnt) begin
            arb_addr = if_addr_i;
        end else if (arb_d_gnt) begin
            arb_addr = d_addr_i;
        end else begin
            arb_addr = last_addr_q;
        end
        last_addr_d = arb_addr;

        if (arb_if_gnt) begin
            resp_src_d = RespIf;
        end else if (arb_d_gnt && !d_we_i) begin
            resp_src_d = RespD;
        end else begin
            resp_src_d = RespNone;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr_q <= '0;
            resp_src_q  <= RespNone;
        end else begin
            last_addr_q <= last_addr_d;
            resp_src_q  <= resp_src_d;
        end
    end

    ram_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req_i   (if_req_i),
        .if_gnt_i   (arb_if_gnt),
        .if_lost_i  (if_req_i && arb_d_gnt),
        .force_if_o (force_if)
    );

    always_comb begin
        if_gnt_o      = rst_n && arb_if_gnt;
        d_gnt_o       = rst_n && arb_d_gnt;
        ram_wren_o    = rst_n && arb_d_gnt && d_we_i;
        ram_address_o = rst_n ? arb_addr : '0;
        ram_data_o    = ram_wren_o ? d_wdata_i : '0;
        if_rvalid_o   = (resp_src_q == RespIf);
        d_rvalid_o    = (resp_src_q == RespD);
        if_rdata_o    = ram_q_i;
        d_rdata_o     = ram_q_i;
    end

`ifdef RAM_ARB_STATS_EN
    logic [31:0] stat_if_q, stat_if_d;
    logic [31:0] stat_d_q, stat_d_d;
    logic [31:0] stat_cf_q, stat_cf_d;

    // Counters saturate at all-ones; clear wins over increment.
    always_comb begin
        stat_if_d = stat_if_q;
        stat_d_d  = stat_d_q;
        stat_cf_d = stat_cf_q;
        if (stat_clr_i) begin
            stat_if_d = '0;
            stat_d_d  = '0;
            stat_cf_d = '0;
        end else begin
            if (arb_if_gnt && (stat_if_q != '1)) begin
                stat_if_d = stat_if_q + 32'd1;
            end
            if (arb_d_gnt && (stat_d_q != '1)) begin
                stat_d_d = stat_d_q + 32'd1;
            end
            if (if_req_i && d_req_i && (stat_cf_q != '1)) begin
                stat_cf_d = stat_cf_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_if_q <= '0;
            stat_d_q  <= '0;
            stat_cf_q <= '0;
        end else begin
            stat_if_q <= stat_if_d;
            stat_d_q  <= stat_d_d;
            stat_cf_q <= stat_cf_d;
        end
    end

    assign stat_if_grants_o = stat_if_q;
    assign stat_d_grants_o  = stat_d_q;
    assign stat_conflicts_o = stat_cf_q;
`else
    // Statistics disabled: no counters or extra ports.
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized run
// against a behavioural model; stats checks when RAM_ARB_STATS_EN is defined.
module tb_ram_arbiter;

    localparam int unsigned AW    = 30;
    localparam int unsigned DW    = 32;
    localparam int          LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;

    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, ram_wren;
    logic [DW-1:0] if_rdata, d_rdata, ram_data;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_q;

    logic          if_gnt0, if_rvalid0, d_gnt0, d_rvalid0, ram_wren0;
    logic [DW-1:0] if_rdata0, d_rdata0, ram_data0;
    logic [AW-1:0] ram_address0;

`ifdef RAM_ARB_STATS_EN
    logic          stat_clr = 1'b0;
    logic [31:0]   st_if, st_d, st_cf, st_if0, st_d0, st_cf0;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem     [0:63];
    logic [DW-1:0] ref_mem [0:63];

    always #5 clk = ~clk;

    // Synchronous-read RAM, read-first on a same-cycle write.
    always @(posedge clk) begin
        ram_q <= mem[ram_address[5:0]];
        if (ram_wren) mem[ram_address[5:0]] = ram_data;
    end

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .ram_wren_o(ram_wren), .ram_address_o(ram_address), .ram_data_o(ram_data),
        .ram_q_i(ram_q)
`ifdef RAM_ARB_STATS_EN
        , .stat_clr_i(stat_clr), .stat_if_grants_o(st_if), .stat_d_grants_o(st_d),
        .stat_conflicts_o(st_cf)
`endif
    );

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt0),
        .if_rvalid_o(if_rvalid0), .if_rdata_o(if_rdata0),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt0), .d_rvalid_o(d_rvalid0), .d_rdata_o(d_rdata0),
        .ram_wren_o(ram_wren0), .ram_address_o(ram_address0), .ram_data_o(ram_data0),
        .ram_q_i(ram_q)
`ifdef RAM_ARB_STATS_EN
        , .stat_clr_i(stat_clr), .stat_if_grants_o(st_if0), .stat_d_grants_o(st_d0),
        .stat_conflicts_o(st_cf0)
`endif
    );

    task automatic apply(input logic ir, input logic [AW-1:0] ia, input logic dr,
                         input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
        @(negedge clk);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apply(1'b1, 30'd3, 1'b1, 1'b1, 30'd7, 32'h12345678);
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL rst_if_gnt got %b want 0", if_gnt); end
        checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL rst_d_gnt got %b want 0", d_gnt); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got %b want 0", ram_wren); end
        checks++; if (ram_address !== 30'd0) begin errors++; $display("FAIL rst_addr got %h want 0", ram_address); end
        checks++; if (ram_data !== 32'd0) begin errors++; $display("FAIL rst_data got %h want 0", ram_data); end
        checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_rvalid got %b%b want 00", if_rvalid, d_rvalid);
        end
        apply(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_only();
        apply(1'b1, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL fo_if_gnt got %b want 1", if_gnt); end
        checks++; if (ram_address !== 30'd0) begin errors++; $display("FAIL fo_addr got %h want 0", ram_address); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL fo_wren got %b want 0", ram_wren); end
        apply(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        checks++; if (if_rvalid !== 1'b1) begin errors++; $display("FAIL fo_if_rvalid got %b want 1", if_rvalid); end
        checks++; if (if_rdata !== 32'h20080020) begin errors++; $display("FAIL fo_if_rdata got %h want 20080020", if_rdata); end
        checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL fo_d_rvalid got %b want 0", d_rvalid); end
    endtask

    task automatic test_write_read();
        apply(1'b0, 30'd0, 1'b1, 1'b1, 30'd5, 32'hDEADBEEF);
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL wr_d_gnt got %b want 1", d_gnt); end
        checks++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL wr_wren got %b want 1", ram_wren); end
        checks++; if (ram_address !== 30'd5) begin errors++; $display("FAIL wr_addr got %h want 5", ram_address); end
        checks++; if (ram_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data got %h want deadbeef", ram_data); end
        apply(1'b0, 30'd0, 1'b1, 1'b0, 30'd5, 32'd0);
        checks++; if (d_gnt !== 1'b1 || ram_wren !== 1'b0) begin
            errors++; $display("FAIL rd_gnt_wren got %b%b want 10", d_gnt, ram_wren);
        end
        checks++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
            errors++; $display("FAIL wr_no_resp got %b%b want 00", if_rvalid, d_rvalid);
        end
        apply(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        checks++; if (d_rvalid !== 1'b1) begin errors++; $display("FAIL rd_d_rvalid got %b want 1", d_rvalid); end
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_d_rdata got %h want deadbeef", d_rdata); end
        checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL rd_if_rvalid got %b want 0", if_rvalid); end
        checks++; if (ram_address !== 30'd5 || ram_wren !== 1'b0) begin
            errors++; $display("FAIL idle_hold got addr %h wren %b want 5 0", ram_address, ram_wren);
        end
    endtask

    task automatic test_starvation();
        logic exp_if;
        apply(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 30'd8, 1'b1, 1'b0, 30'd0, 32'd0);
            exp_if = ((i % (LIMIT + 1)) == LIMIT);
            checks++; if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
                errors++; $display("FAIL starve cyc %0d got if/d %b%b want %b%b", i, if_gnt, d_gnt, exp_if, !exp_if);
            end
            checks++; if (if_gnt0 !== 1'b0 || d_gnt0 !== 1'b1) begin
                errors++; $display("FAIL starve0 cyc %0d got if/d %b%b want 01", i, if_gnt0, d_gnt0);
            end
        end
        apply(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
    endtask

    task automatic test_back_to_back();
        apply(1'b1, 30'd8, 1'b0, 1'b0, 30'd0, 32'd0);
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL b2b_if_gnt got %b want 1", if_gnt); end
        apply(1'b0, 30'd0, 1'b1, 1'b0, 30'd0, 32'd0);
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL b2b_d_gnt got %b want 1", d_gnt); end
        checks++; if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin
            errors++; $display("FAIL b2b_rv1 got if/d %b%b want 10", if_rvalid, d_rvalid);
        end
        checks++; if (if_rdata !== 32'h11111111) begin errors++; $display("FAIL b2b_if_rdata got %h want 11111111", if_rdata); end
        apply(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        checks++; if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin
            errors++; $display("FAIL b2b_rv2 got if/d %b%b want 01", if_rvalid, d_rvalid);
        end
        checks++; if (d_rdata !== 32'h20080020) begin errors++; $display("FAIL b2b_d_rdata got %h want 20080020", d_rdata); end
    endtask

    task automatic test_reset_mid_read();
        logic exp_if;
        for (int i = 0; i < 3; i++) apply(1'b1, 30'd8, 1'b1, 1'b0, 30'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || ram_wren !== 1'b0) begin
            errors++; $display("FAIL mid_rst_gnt got if/d/wren %b%b%b want 000", if_gnt, d_gnt, ram_wren);
        end
        checks++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_rvalid got if/d %b%b want 00", if_rvalid, d_rvalid);
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                checks++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
                    errors++; $display("FAIL post_rst_rvalid got if/d %b%b want 00", if_rvalid, d_rvalid);
                end
            end else begin
                apply(1'b1, 30'd8, 1'b1, 1'b0, 30'd0, 32'd0);
            end
            exp_if = (k == LIMIT);
            checks++; if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
                errors++; $display("FAIL post_rst cyc %0d got if/d %b%b want %b%b", k, if_gnt, d_gnt, exp_if, !exp_if);
            end
        end
        apply(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
    endtask

    task automatic test_random();
        logic          p_if, p_d, p_we, e_ig, e_dg, e_wren;
        logic [AW-1:0] p_ia, p_da, e_addr, last_addr;
        logic [DW-1:0] p_wd, exp_rdata;
        int            lost, exp_resp;
        do_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        p_if = 1'b0; p_d = 1'b0; p_we = 1'b0; p_ia = '0; p_da = '0; p_wd = '0;
        lost = 0; exp_resp = 0; exp_rdata = '0; last_addr = '0;
        for (int c = 0; c < 300; c++) begin
            if (!p_if && ($urandom_range(0, 2) != 0)) begin
                p_if = 1'b1; p_ia = AW'($urandom_range(0, 15));
            end
            if (!p_d && ($urandom_range(0, 2) != 0)) begin
                p_d = 1'b1; p_we = 1'($urandom_range(0, 1));
                p_da = AW'($urandom_range(0, 15)); p_wd = $urandom;
            end
            apply(p_if, p_ia, p_d, p_we, p_da, p_wd);
            e_ig   = p_if && (!p_d || (LIMIT != 0 && lost == LIMIT));
            e_dg   = p_d && !e_ig;
            e_wren = e_dg && p_we;
            e_addr = e_ig ? p_ia : (e_dg ? p_da : last_addr);
            checks++; if (if_gnt !== e_ig || d_gnt !== e_dg) begin
                errors++; $display("FAIL rnd_gnt cyc %0d got if/d %b%b want %b%b", c, if_gnt, d_gnt, e_ig, e_dg);
            end
            checks++; if (ram_wren !== e_wren || ram_address !== e_addr) begin
                errors++; $display("FAIL rnd_ram cyc %0d got wren %b addr %h want %b %h", c, ram_wren, ram_address, e_wren, e_addr);
            end
            if (e_wren) begin
                checks++; if (ram_data !== p_wd) begin
                    errors++; $display("FAIL rnd_wdata cyc %0d got %h want %h", c, ram_data, p_wd);
                end
            end
            checks++; if (if_rvalid !== (exp_resp == 1) || d_rvalid !== (exp_resp == 2)) begin
                errors++; $display("FAIL rnd_rvalid cyc %0d got if/d %b%b want src %0d", c, if_rvalid, d_rvalid, exp_resp);
            end
            if (exp_resp != 0) begin
                checks++; if ((exp_resp == 1 ? if_rdata : d_rdata) !== exp_rdata) begin
                    errors++; $display("FAIL rnd_rdata cyc %0d got %h want %h", c,
                                       (exp_resp == 1 ? if_rdata : d_rdata), exp_rdata);
                end
            end
            exp_resp  = e_ig ? 1 : ((e_dg && !p_we) ? 2 : 0);
            exp_rdata = ref_mem[e_addr[5:0]];
            if (e_wren) ref_mem[e_addr[5:0]] = p_wd;
            lost      = (!p_if || e_ig) ? 0 : lost + 1;
            last_addr = e_addr;
            if (e_ig) p_if = 1'b0;
            if (e_dg) p_d = 1'b0;
        end
        apply(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
    endtask

`ifdef RAM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        #1;
        checks++; if (st_if !== 32'd0 || st_d !== 32'd0 || st_cf !== 32'd0) begin
            errors++; $display("FAIL stats_rst got %0d %0d %0d want 0 0 0", st_if, st_d, st_cf);
        end
        for (int i = 0; i < 10; i++) apply(1'b1, 30'd8, 1'b1, 1'b0, 30'd0, 32'd0);
        apply(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        checks++; if (st_cf !== 32'd10) begin errors++; $display("FAIL stats_conf got %0d want 10", st_cf); end
        checks++; if (st_d !== 32'd8) begin errors++; $display("FAIL stats_d got %0d want 8", st_d); end
        checks++; if (st_if !== 32'd2) begin errors++; $display("FAIL stats_if got %0d want 2", st_if); end
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        #1;
        checks++; if (st_if !== 32'd0 || st_d !== 32'd0 || st_cf !== 32'd0) begin
            errors++; $display("FAIL stats_clr got %0d %0d %0d want 0 0 0", st_if, st_d, st_cf);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA5000000 | 32'(i);
        mem[0] = 32'h20080020;
        mem[8] = 32'h11111111;
        test_reset();
        test_fetch_only();
        test_write_read();
        test_back_to_back();
        test_starvation();
        test_reset_mid_read();
        test_random();
`ifdef RAM_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port, word-addressed, synchronous-read RAM between the instruction-fetch port and the load/store data port of the CPU.
- Each cycle it selects at most one requester and drives the RAM address, write-enable and write-data for that requester.
- It tracks which requester issued the read, so the RAM output one cycle later is steered back to that requester.
- Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 30, word-address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive fetch-lost cycles before fetch is force-granted; 0 = pure data priority, no forcing.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until granted.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held until granted.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data read data valid (reads only).
- d_rdata  out  DATA_W  data read data.
- ram_wren  out  1  to RAM wren.
- ram_address  out  ADDR_W  to RAM address.
- ram_data  out  DATA_W  to RAM data.
- ram_q  in  DATA_W  from RAM q.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low on rst_n.
- Grant logic is combinational from req inputs and registered state.
  - Outputs if_gnt, d_gnt, ram_wren, ram_address and ram_data are combinational; the RAM registers them.
  - While rst_n=0: both gnt=0, ram_wren=0, ram_address=0, ram_data=0.
- Arbitration each cycle:
  - Only one requesting: grant it.
  - Both requesting: grant data, unless force_if=1, in which case grant fetch.
  - Neither requesting: ram_wren=0, ram_address holds the last granted address (no spurious write).
- Starvation counter wait_cnt (width clog2(STARVE_LIMIT+1), reset 0):
  - Increments when both request and data wins.
  - Clears when fetch is granted or if_req=0.
  - force_if = (STARVE_LIMIT!=0) && (wait_cnt==STARVE_LIMIT).
- Granted data write: ram_wren=1, ram_data=d_wdata in the grant cycle. No response is issued.
- Granted read: ram_wren=0. The response register resp_src (NONE/IF/D, reset NONE) is set at the clock edge ending the grant cycle.
- Response cycle (grant+1):
  - if_rvalid = (resp_src==IF); d_rvalid = (resp_src==D).
  - Both rdata outputs = ram_q, combinational. rdata is don't-care when rvalid=0.
  - Latency is exactly 1 cycle; there is no response backpressure.
- Fully pipelined: a new grant may occur in the same cycle as a response (back-to-back reads at 1/cycle).
- A data write at cycle N followed by a read of the same address at N+1 returns the new data.
- Reset mid-operation: a pending response is discarded (resp_src=NONE, rvalid=0), and wait_cnt=0.
- Requesters must hold req/addr/wdata stable until gnt. The arbiter does not latch unaccepted requests.

Optional Feature:
- RAM_ARB_STATS_EN defined: adds three 32-bit counters plus ports.
  - stat_clr in 1: synchronous clear.
  - stat_if_grants out 32.
  - stat_d_grants out 32.
  - stat_conflicts out 32: cycles with both req high.
  - Counters reset to 0 on rst_n, saturate at all-ones, and clear takes priority over increment.
- Undefined: ports and counters absent; arbitration behaviour is identical.

Decomposition:
- Shared package ram_arb_pkg:
  - resp_src enum: NONE=2'd0, IF=2'd1, D=2'd2.
  - Default ADDR_W/DATA_W constants.
- One natural sub-module: ram_arb_starve_cnt (wait_cnt plus force_if generation).

Test Plan:
- Fetch only: if_req=1, if_addr=0 held 1 cycle -> if_gnt=1, ram_address=0, ram_wren=0; next cycle if_rvalid=1, if_rdata=32'h20080020 (RAM preload word 0), d_rvalid=0.
- Data write then read: d_we=1, d_addr=5, d_wdata=32'hDEADBEEF granted at N; d_we=0, d_addr=5 at N+1 -> d_rvalid=1 at N+2 with 32'hDEADBEEF; if_rvalid=0 throughout.
- Conflict with starvation, STARVE_LIMIT=4: if_req=1 and d_req=1 continuously -> data granted 4 cycles, fetch granted cycle 5, pattern repeats with period 5. With STARVE_LIMIT=0, fetch is never granted.
- Back-to-back alternating reads: fetch addr 8 at N, data addr 0 at N+1 -> if_rvalid at N+1 with 32'h11111111, d_rvalid at N+2 with 32'h20080020; never both rvalid in one cycle.
- Reset mid-read: read granted at N, rst_n=0 during N+1 -> rvalid=0, gnt=0, ram_wren=0; after release, first grant behaves as from fresh reset (wait_cnt=0).
- RAM_ARB_STATS_EN: 10 conflict cycles with STARVE_LIMIT=4 -> stat_conflicts=10, stat_d_grants=8, stat_if_grants=2; stat_clr pulse -> all 0 next cycle.
